// File: rtl/fsk_codeword_receiver.sv
// Frame receiver between the FSK demodulator and the Hamming(12,8) decoder.
// It hunts for the sync word, then emits fixed-length frames of 12-bit codewords.
module fsk_codeword_receiver #(
    parameter logic [7:0] SYNC_WORD    = 8'hD3,
    parameter int         CW_PER_FRAME = 4,
    parameter int         TIMEOUT      = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_stb,
    output logic [11:0] cw_out,
    output logic        cw_valid,
    output logic [7:0]  cw_index,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0]  LAST_CW   = 8'(CW_PER_FRAME - 1);
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  sync_sr_q, sync_sr_d;
    logic [11:0] cw_sr_q, cw_sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cw_cnt_q, cw_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;

    logic [11:0] cw_out_q, cw_out_d;
    logic        cw_valid_q, cw_valid_d;
    logic [7:0]  cw_index_q, cw_index_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sync_sr_q     <= 8'h00;
            cw_sr_q       <= 12'h000;
            bit_cnt_q     <= 4'd0;
            cw_cnt_q      <= 8'd0;
            idle_cnt_q    <= 16'd0;
            cw_out_q      <= 12'h000;
            cw_valid_q    <= 1'b0;
            cw_index_q    <= 8'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_sr_q     <= sync_sr_d;
            cw_sr_q       <= cw_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            cw_cnt_q      <= cw_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            cw_out_q      <= cw_out_d;
            cw_valid_q    <= cw_valid_d;
            cw_index_q    <= cw_index_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sync_sr_d     = sync_sr_q;
        cw_sr_d       = cw_sr_q;
        bit_cnt_d     = bit_cnt_q;
        cw_cnt_d      = cw_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        cw_out_d      = cw_out_q;
        cw_index_d    = cw_index_q;
        cw_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            HUNT: begin
                if (bit_stb) begin
                    sync_sr_d = {sync_sr_q[6:0], bit_in};
                    if (sync_sr_d == SYNC_WORD) begin
                        state_d       = COLLECT;
                        bit_cnt_d     = 4'd0;
                        cw_cnt_d      = 8'd0;
                        idle_cnt_d    = 16'd0;
                        frame_start_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bit_stb) begin
                    // Codeword bits arrive LSB first, so shift in from the top.
                    cw_sr_d    = {bit_in, cw_sr_q[11:1]};
                    idle_cnt_d = 16'd0;
                    if (bit_cnt_q == 4'd11) begin
                        cw_out_d   = cw_sr_d;
                        cw_index_d = cw_cnt_q;
                        cw_valid_d = 1'b1;
                        bit_cnt_d  = 4'd0;
                        cw_cnt_d   = cw_cnt_q + 8'd1;
                        if (cw_cnt_q == LAST_CW) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                            sync_sr_d    = 8'h00;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                    sync_sr_d   = 8'h00;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        busy_d = (state_d == COLLECT);
    end

    assign cw_out      = cw_out_q;
    assign cw_valid    = cw_valid_q;
    assign cw_index    = cw_index_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fsk_codeword_receiver.sv
// Bench for fsk_codeword_receiver: directed scenarios plus random frames,
// checked every cycle against a bit-list model and by literal expectations.
module tb_fsk_codeword_receiver;

    localparam logic [7:0] SYNC = 8'hD3;
    localparam int CPF = 4;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_stb;
    logic [11:0] cw_out;
    logic        cw_valid;
    logic [7:0]  cw_index;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    fsk_codeword_receiver #(
        .SYNC_WORD   (SYNC),
        .CW_PER_FRAME(CPF),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_stb    (bit_stb),
        .cw_out     (cw_out),
        .cw_valid   (cw_valid),
        .cw_index   (cw_index),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state
    bit         in_frame = 1'b0;
    logic [7:0] hist = 8'h00;
    bit         payload[$];
    int         gap = 0;
    logic [11:0] m_cw = 12'h000;
    logic [7:0]  m_idx = 8'h00;
    bit m_valid = 0, m_start = 0, m_done = 0, m_err = 0, m_busy = 0;

    // observation log
    logic [11:0] obs_cw[$];
    logic [7:0]  obs_idx[$];
    int n_start = 0, n_done = 0, n_err = 0;
    int start_cyc = 0, err_cyc = 0, last_stb_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: the frame is a list of received payload bits; codeword k is
    // bits 12k..12k+11 with the first bit as bit 0; a timeout is TO edges
    // with no strobe since the last accepted one.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_start = 0; m_valid = 0; m_done = 0; m_err = 0;
            if (!rst_n) begin
                in_frame = 0; hist = 8'h00; payload.delete(); gap = 0;
                m_cw = 12'h000; m_idx = 8'h00;
            end else if (!in_frame) begin
                if (bit_stb) begin
                    hist = {hist[6:0], bit_in};
                    if (hist == SYNC) begin
                        in_frame = 1; m_start = 1; payload.delete(); gap = 0;
                    end
                end
            end else if (bit_stb) begin
                payload.push_back(bit_in);
                gap = 0;
                if (payload.size() % 12 == 0) begin
                    logic [11:0] w;
                    w = 12'h000;
                    for (int i = 0; i < 12; i++) w[i] = payload[payload.size() - 12 + i];
                    m_cw = w;
                    m_idx = 8'(payload.size() / 12 - 1);
                    m_valid = 1;
                    if (payload.size() == 12 * CPF) begin
                        m_done = 1; in_frame = 0; hist = 8'h00;
                    end
                end
            end else begin
                gap++;
                if (gap == TO) begin
                    m_err = 1; in_frame = 0; hist = 8'h00;
                end
            end
            m_busy = in_frame;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("cw_out", 32'(cw_out), 32'(m_cw));
                check("cw_valid", 32'(cw_valid), 32'(m_valid));
                check("cw_index", 32'(cw_index), 32'(m_idx));
                check("frame_start", 32'(frame_start), 32'(m_start));
                check("frame_done", 32'(frame_done), 32'(m_done));
                check("frame_err", 32'(frame_err), 32'(m_err));
                check("busy", 32'(busy), 32'(m_busy));
            end
            if (cw_valid === 1'b1) begin
                obs_cw.push_back(cw_out);
                obs_idx.push_back(cw_index);
            end
            if (frame_start === 1'b1) begin n_start++; start_cyc = cyc; end
            if (frame_done === 1'b1) n_done++;
            if (frame_err === 1'b1) begin n_err++; err_cyc = cyc; end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_stb = 1'b1;
        bit_in = b;
        last_stb_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_stb = 1'b0;
            bit_in = 1'($urandom);
        end
    endtask

    task automatic send_sync();
        for (int i = 7; i >= 0; i--) send_bit(SYNC[i]);
    endtask

    task automatic send_cw(input logic [11:0] w, input int max_gap);
        for (int i = 0; i < 12; i++) begin
            send_bit(w[i]);
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
        end
    endtask

    logic [11:0] basic_cw[4];
    int b_start, b_done, b_err, b_val;

    task automatic snap();
        b_start = n_start; b_done = n_done; b_err = n_err; b_val = obs_cw.size();
    endtask

    initial begin
        rst_n = 1'b0; bit_stb = 1'b0; bit_in = 1'b0;
        basic_cw[0] = 12'hA5C; basic_cw[1] = 12'h123;
        basic_cw[2] = 12'hFFF; basic_cw[3] = 12'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_cw_out", 32'(cw_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_cw_index", 32'(cw_index), 32'h0);

        // basic frame
        snap();
        send_sync();
        for (int k = 0; k < 4; k++) send_cw(basic_cw[k], 0);
        idle(3);
        check("basic_starts", n_start - b_start, 1);
        check("basic_valids", obs_cw.size() - b_val, 4);
        for (int k = 0; k < 4; k++) begin
            check("basic_cw", 32'(obs_cw[b_val + k]), 32'(basic_cw[k]));
            check("basic_idx", 32'(obs_idx[b_val + k]), k);
        end
        check("basic_done", n_done - b_done, 1);
        check("basic_err", n_err - b_err, 0);

        // sync hunting: 0,1,1,0,1,0,0,1 does not match, the 9th bit completes D3
        snap();
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        idle(2);
        check("hunt_no_early_start", n_start - b_start, 0);
        send_bit(1);
        idle(2);
        check("hunt_start_once", n_start - b_start, 1);
        check("hunt_start_cycle", start_cyc - last_stb_cyc, 0);
        send_cw(12'h5A5, 0);
        idle(2);
        check("hunt_cw", 32'(obs_cw[b_val]), 32'h5A5);
        check("hunt_idx", 32'(obs_idx[b_val]), 0);
        for (int k = 1; k < CPF; k++) send_cw(12'($urandom), 2);
        idle(3);

        // timeout after 5 codeword bits
        snap();
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        idle(TO + 5);
        check("to_err_count", n_err - b_err, 1);
        check("to_err_latency", err_cyc - last_stb_cyc, TO);
        check("to_busy", 32'(busy), 0);
        check("to_no_valid", obs_cw.size() - b_val, 0);
        snap();
        send_sync();
        for (int k = 0; k < CPF; k++) send_cw(basic_cw[3 - k], 0);
        idle(3);
        check("to_recover_done", n_done - b_done, 1);
        check("to_recover_cw", 32'(obs_cw[b_val]), 32'h000);

        // strobe arriving exactly at the deadline
        snap();
        send_sync();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        idle(TO - 1);
        for (int i = 3; i < 12; i++) send_bit(1'b0);
        for (int k = 1; k < CPF; k++) send_cw(12'($urandom), 0);
        idle(3);
        check("deadline_no_err", n_err - b_err, 0);
        check("deadline_done", n_done - b_done, 1);
        check("deadline_cw", 32'(obs_cw[b_val]), 32'h007);

        // back-to-back frames on a continuous strobe
        snap();
        for (int f = 0; f < 2; f++) begin
            send_sync();
            for (int k = 0; k < CPF; k++) send_cw(12'($urandom), 0);
        end
        idle(3);
        check("b2b_valids", obs_cw.size() - b_val, 8);
        check("b2b_done", n_done - b_done, 2);
        check("b2b_start", n_start - b_start, 2);

        // reset after 6 bits of the first codeword
        snap();
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0; bit_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_cw_out", 32'(cw_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cw_index", 32'(cw_index), 0);
        idle(TO + 2);
        check("rst_no_valid", obs_cw.size() - b_val, 0);
        check("rst_no_err", n_err - b_err, 0);
        send_sync();
        for (int k = 0; k < CPF; k++) send_cw(basic_cw[k], 1);
        idle(3);
        check("rst_after_done", n_done - b_done, 1);
        check("rst_after_cw", 32'(obs_cw[b_val + 1]), 32'h123);

        // random frames with noise, gaps and occasional stalls
        for (int f = 0; f < 30; f++) begin
            int junk;
            junk = $urandom_range(10, 0);
            for (int i = 0; i < junk; i++) begin
                send_bit(1'($urandom));
                if ($urandom_range(3, 0) == 0) idle($urandom_range(4, 1));
            end
            send_sync();
            for (int k = 0; k < CPF; k++) begin
                if ($urandom_range(15, 0) == 0) idle(TO + $urandom_range(3, 0));
                send_cw(12'($urandom), ($urandom_range(1, 0) == 0) ? 0 : TO - 1);
            end
            idle($urandom_range(3, 0));
        end
        idle(TO + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
